exec_stage: RTL and testbench
=============================

Name: exec_stage

Overview:
- Execute stage directly downstream of the 4-entry, 32-bit register file.
- Consumes the two read operands plus a destination register index, computes an ALU or iterative multiply result, and drives the register file's write port.
- The write port is WriteData, WriteReg and RegWrite.
- Single-cycle ops complete in 1 cycle; MUL uses a 32-step shift-add sequencer. Handshake is valid/ready.

Parameters:
- DATA_W, 32, operand/result width; also the MUL iteration count.
- REG_AW, 2, register index width (4 registers).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- issue_valid  input  1  operation presented this cycle.
- issue_ready  output  1  stage can accept an operation (combinational: state==IDLE and not reset).
- op  input  3  opcode, encodings below.
- operand_a  input  DATA_W  first operand (from register file ReadData1).
- operand_b  input  DATA_W  second operand (from register file ReadData2).
- dest_reg  input  REG_AW  destination register index.
- wb_en  input  1  result is to be written back.
- WriteData  output  DATA_W  registered result, to register file.
- WriteReg  output  REG_AW  registered destination, to register file.
- RegWrite  output  1  one-cycle write strobe, to register file.
- zero  output  1  registered: WriteData == 0.
- busy  output  1  registered: MUL sequence in progress.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset is synchronous and active-high.
  - On a reset edge: state=IDLE, WriteData=0, WriteReg=0, RegWrite=0, zero=0, busy=0, counter=0, all internal latches cleared.
  - Reset wins over every other event. Reset during MUL or WB aborts with no RegWrite pulse.
- Opcodes (all arithmetic mod 2^DATA_W, no overflow flag):
  - 000 ADD: a+b.
  - 001 SUB: a−b.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SLT: signed a<b gives 1, else 0, zero-extended.
  - 110 MUL: low DATA_W bits of a×b.
  - 111 PASSB: b.
- Accept: at a rising edge with issue_valid && issue_ready. Operands, op, dest_reg and wb_en are captured at that edge. The upstream stage may change inputs the following cycle.
- States:
  - IDLE: issue_ready=1.
    - Accept of a non-MUL op: result computed combinationally and registered into WriteData/zero; WriteReg=dest_reg; RegWrite=wb_en; go to WB.
    - Accept of MUL: load multiplicand=a, multiplier=b, acc=0, counter=DATA_W, busy=1; go to MUL.
    - issue_valid=0: remain in IDLE.
  - MUL: issue_ready=0. Each edge performs one step:
    - if multiplier[LSB] then acc += multiplicand;
    - multiplicand <<= 1; multiplier >>= 1; counter−−.
    - On the step where counter==1: WriteData=final acc, zero updated, WriteReg=latched dest, RegWrite=latched wb_en, busy=0; go to WB.
  - WB: issue_ready=0; RegWrite (if set) is high for exactly this cycle. Next edge: RegWrite=0; go to IDLE.
- Latency:
  - Non-MUL accepted at edge N: RegWrite/WriteData valid from N to N+1; register file captures at N+1; issue_ready returns after N+1.
  - Throughput for non-MUL is 1 op per 2 cycles.
  - MUL accepted at edge N: steps at N+1..N+DATA_W; result and RegWrite valid from N+DATA_W to N+DATA_W+1.
- wb_en=0: WriteData, zero and WriteReg still update; RegWrite stays 0 through WB.
- WriteData, WriteReg and zero hold their last values until the next completion. RegWrite is never high for more than one consecutive cycle.
- issue_valid while not ready: ignored, not queued. Inputs may change freely while busy.
- MUL with either operand 0 still takes the full DATA_W steps; no early termination.

Test Plan:
- Reset held 2 cycles, then released -> all outputs 0, issue_ready=1 on the first post-reset cycle, no RegWrite.
- ADD a=0x7FFFFFFF, b=1, dest=2, wb_en=1 -> next cycle WriteData=0x80000000, WriteReg=2, RegWrite=1 for exactly one cycle; then issue_ready=1.
- SUB a=5, b=5, then SLT a=0xFFFFFFFF (−1), b=1 -> SUB: WriteData=0, zero=1. SLT: WriteData=1, zero=0.
- MUL a=0x00010003, b=0x00020005 -> busy=1 for 32 cycles; RegWrite pulses once at edge N+32 with WriteData=0x000B000F (low 32 bits); issue_valid held high during busy is not accepted.
- MUL started, then reset asserted at step 10 -> no RegWrite ever; all outputs 0; idle and ready after reset release.
- AND with wb_en=0, a=0xF0F0F0F0, b=0xFF00FF00 -> WriteData=0xF000F000, RegWrite stays 0; next op accepted 2 cycles after the first.

Source files
------------

// File: rtl/exec_stage.sv
// rtl/exec_stage.sv - execute stage: single-cycle ALU plus shift-add multiplier feeding the register file write port
// Three-state FSM: IDLE accepts, MUL iterates DATA_W steps, WB holds the one-cycle write strobe.
module exec_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic [REG_AW-1:0] dest_reg,
  input  logic              wb_en,
  output logic [DATA_W-1:0] WriteData,
  output logic [REG_AW-1:0] WriteReg,
  output logic              RegWrite,
  output logic              zero,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_SLT   = 3'b101;
  localparam logic [2:0] OP_MUL   = 3'b110;
  localparam logic [2:0] OP_PASSB = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t state, next_state;

  logic [DATA_W-1:0] multiplicand;
  logic [DATA_W-1:0] multiplier;
  logic [DATA_W-1:0] acc;
  logic [CNT_W-1:0]  counter;
  logic [REG_AW-1:0] lat_dest;
  logic              lat_wb;

  logic              accept;
  logic              last_step;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] mul_sum;

  assign accept    = issue_valid && issue_ready;
  assign last_step = (state == S_MUL) && (counter == CNT_W'(1));
  assign mul_sum   = acc + (multiplier[0] ? multiplicand : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          next_state = (op == OP_MUL) ? S_MUL : S_WB;
        end
      end
      S_MUL: begin
        if (last_step) begin
          next_state = S_WB;
        end
      end
      S_WB:    next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    issue_ready = (state == S_IDLE) && !reset;
  end

  always_comb begin
    alu_result = '0;
    case (op)
      OP_ADD:   alu_result = operand_a + operand_b;
      OP_SUB:   alu_result = operand_a - operand_b;
      OP_AND:   alu_result = operand_a & operand_b;
      OP_OR:    alu_result = operand_a | operand_b;
      OP_XOR:   alu_result = operand_a ^ operand_b;
      OP_SLT:   alu_result = {{(DATA_W-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
      OP_PASSB: alu_result = operand_b;
      default:  alu_result = '0;
    endcase
  end

  // RegWrite defaults low every cycle so it can never stay high past the WB cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      WriteData    <= '0;
      WriteReg     <= '0;
      RegWrite     <= 1'b0;
      zero         <= 1'b0;
      busy         <= 1'b0;
      multiplicand <= '0;
      multiplier   <= '0;
      acc          <= '0;
      counter      <= '0;
      lat_dest     <= '0;
      lat_wb       <= 1'b0;
    end else begin
      RegWrite <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (op == OP_MUL) begin
              multiplicand <= operand_a;
              multiplier   <= operand_b;
              acc          <= '0;
              counter      <= CNT_W'(DATA_W);
              busy         <= 1'b1;
              lat_dest     <= dest_reg;
              lat_wb       <= wb_en;
            end else begin
              WriteData <= alu_result;
              zero      <= (alu_result == '0);
              WriteReg  <= dest_reg;
              RegWrite  <= wb_en;
            end
          end
        end
        S_MUL: begin
          acc          <= mul_sum;
          multiplicand <= multiplicand << 1;
          multiplier   <= multiplier >> 1;
          counter      <= counter - CNT_W'(1);
          if (last_step) begin
            WriteData <= mul_sum;
            zero      <= (mul_sum == '0);
            WriteReg  <= lat_dest;
            RegWrite  <= lat_wb;
            busy      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// tb/tb_exec_stage.sv - scoreboard bench for exec_stage
module tb_exec_stage;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_SLT   = 3'b101;
  localparam logic [2:0] OP_MUL   = 3'b110;
  localparam logic [2:0] OP_PASSB = 3'b111;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  dreg;
    logic        rw;
    logic        z;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic        issue_ready;
  logic [2:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [1:0]  dest_reg;
  logic        wb_en;
  logic [31:0] WriteData;
  logic [1:0]  WriteReg;
  logic        RegWrite;
  logic        zero;
  logic        busy;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;

  exec_stage #(.DATA_W(32), .REG_AW(2)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .op(op), .operand_a(operand_a), .operand_b(operand_b), .dest_reg(dest_reg),
    .wb_en(wb_en), .WriteData(WriteData), .WriteReg(WriteReg), .RegWrite(RegWrite),
    .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (o)
      OP_ADD:   return a + b;
      OP_SUB:   return a - b;
      OP_AND:   return a & b;
      OP_OR:    return a | b;
      OP_XOR:   return a ^ b;
      OP_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_MUL:   return p[31:0];
      default:  return b;
    endcase
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] d, input logic w, input bit push);
    logic [31:0] r;
    @(negedge clk);
    op = o; operand_a = a; operand_b = b; dest_reg = d; wb_en = w; issue_valid = 1'b1;
    checks++;
    if (issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_at_issue got %b want 1", issue_ready);
    end
    r = model(o, a, b);
    if (push) exp_q.push_back('{data: r, dreg: d, rw: w, z: (r == 32'd0)});
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    issue_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; issue_valid = 1'b0; op = '0; operand_a = '0; operand_b = '0;
    dest_reg = '0; wb_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({WriteData, WriteReg, RegWrite, zero, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h/%h/%b/%b/%b want all 0", WriteData, WriteReg, RegWrite, zero, busy);
    end
    checks++;
    if (issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b want 1", issue_ready);
    end
    @(negedge clk);
    checks++;
    if (RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_regwrite got %b want 0", RegWrite);
    end
  endtask

  task automatic test_add();
    exp_t e;
    issue(OP_ADD, 32'h7FFF_FFFF, 32'h1, 2'd2, 1'b1, 1'b1);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if ({WriteData, WriteReg, RegWrite, zero} !== e) begin
      errors++;
      $display("FAIL add_result got %h/%h/%b/%b want %h/%h/%b/%b", WriteData, WriteReg, RegWrite, zero, e.data, e.dreg, e.rw, e.z);
    end
    @(negedge clk);
    checks++;
    if (RegWrite !== 1'b0 || issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL add_pulse_end got rw=%b ready=%b want rw=0 ready=1", RegWrite, issue_ready);
    end
  endtask

  task automatic test_sub_slt();
    exp_t e;
    logic [2:0]  ops[4] = '{OP_SUB, OP_SLT, OP_SLT, OP_SLT};
    logic [31:0] as[4]  = '{32'd5, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
    logic [31:0] bs[4]  = '{32'd5, 32'd1, 32'h8000_0000, 32'h7FFF_FFFF};
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i], 2'(i), 1'b1, 1'b1);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({WriteData, WriteReg, RegWrite, zero} !== e) begin
        errors++;
        $display("FAIL sub_slt_%0d got %h/%h/%b/%b want %h/%h/%b/%b", i, WriteData, WriteReg, RegWrite, zero, e.data, e.dreg, e.rw, e.z);
      end
    end
  endtask

  task automatic test_alu_ops();
    exp_t e;
    logic [2:0] ops[7] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_PASSB};
    for (int i = 0; i < 14; i++) begin
      issue(ops[i % 7], $urandom, $urandom, 2'($urandom_range(0, 3)), 1'b1, 1'b1);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({WriteData, WriteReg, RegWrite, zero} !== e) begin
        errors++;
        $display("FAIL alu_op%0d got %h/%h/%b/%b want %h/%h/%b/%b", ops[i % 7], WriteData, WriteReg, RegWrite, zero, e.data, e.dreg, e.rw, e.z);
      end
    end
  endtask

  task automatic test_mul();
    exp_t e;
    int   busy_cnt = 0;
    bit   rw_seen = 0;
    issue(OP_MUL, 32'h0001_0003, 32'h0002_0005, 2'd1, 1'b1, 1'b1);
    // hold a different request high while busy; it must be ignored
    op = OP_ADD; operand_a = 32'd1; operand_b = 32'd2; dest_reg = 2'd3; wb_en = 1'b1;
    issue_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (RegWrite === 1'b1) begin
        rw_seen = 1;
        break;
      end
      if (busy === 1'b1) busy_cnt++;
    end
    issue_valid = 1'b0;
    checks++;
    if (!rw_seen) begin
      errors++;
      $display("FAIL mul_timeout got no RegWrite want pulse within 100 cycles");
    end
    checks++;
    if (busy_cnt != 32 || (cyc - acc_cyc) != 32) begin
      errors++;
      $display("FAIL mul_latency got busy=%0d lat=%0d want 32/32", busy_cnt, cyc - acc_cyc);
    end
    e = exp_q.pop_front();
    checks++;
    if ({WriteData, WriteReg, RegWrite, zero} !== e) begin
      errors++;
      $display("FAIL mul_result got %h/%h/%b/%b want %h/%h/%b/%b", WriteData, WriteReg, RegWrite, zero, e.data, e.dreg, e.rw, e.z);
    end
    @(negedge clk);
    checks++;
    if (RegWrite !== 1'b0 || busy !== 1'b0 || issue_ready !== 1'b1 || WriteData !== e.data) begin
      errors++;
      $display("FAIL mul_after got rw=%b busy=%b ready=%b data=%h want 0/0/1/%h", RegWrite, busy, issue_ready, WriteData, e.data);
    end
  endtask

  task automatic test_mul_reset();
    int rw_cnt = 0;
    issue(OP_MUL, 32'h1234_5678, 32'h9ABC_DEF1, 2'd3, 1'b1, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({WriteData, WriteReg, RegWrite, zero, busy} !== '0 || issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL mul_reset_state got %h/%h/%b/%b/%b ready=%b want 0s ready=1", WriteData, WriteReg, RegWrite, zero, busy, issue_ready);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (RegWrite !== 1'b0) rw_cnt++;
    end
    checks++;
    if (rw_cnt != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mul_reset_abort got rw_cycles=%0d busy=%b want 0/0", rw_cnt, busy);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   first;
    issue(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 2'd3, 1'b0, 1'b1);
    first = acc_cyc;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if ({WriteData, WriteReg, RegWrite, zero} !== e) begin
      errors++;
      $display("FAIL and_nowb got %h/%h/%b/%b want %h/%h/%b/%b", WriteData, WriteReg, RegWrite, zero, e.data, e.dreg, e.rw, e.z);
    end
    issue(OP_PASSB, 32'h0, 32'h0000_1234, 2'd1, 1'b1, 1'b1);
    checks++;
    if (acc_cyc - first != 2) begin
      errors++;
      $display("FAIL back_to_back_spacing got %0d want 2", acc_cyc - first);
    end
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if ({WriteData, WriteReg, RegWrite, zero} !== e) begin
      errors++;
      $display("FAIL passb_result got %h/%h/%b/%b want %h/%h/%b/%b", WriteData, WriteReg, RegWrite, zero, e.data, e.dreg, e.rw, e.z);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_slt();
    test_alu_ops();
    test_mul();
    test_mul_reset();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
